// File: rtl/hls_macc_obf_param.sv
// Key-locked signed multiply-accumulate engine with the ap_start/ap_done block handshake.
// Two-stage pipeline: a registered product, then an add or subtract chosen by a key bit.
module hls_macc_obf_param #(
   parameter int DATA_W  = 16,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 2*DATA_W+$clog2(N_TERMS),
   parameter int OUT_W   = 16,
   parameter int LOCK_W  = 1024
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic                     ap_start,
   output logic                     ap_done,
   output logic                     ap_idle,
   output logic                     ap_ready,
   input  logic signed [ACC_W-1:0]  acc_init,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   input  logic                     in_vld,
   output logic                     in_rdy,
   output logic signed [OUT_W-1:0]  out_acc,
   output logic                     out_acc_ap_vld,
   output logic                     out_sat,
   input  logic [LOCK_W-1:0]        locking_key
);

   localparam int IW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

   state_t                    state, state_nxt;
   logic [IW-1:0]             term_cnt, p1_idx;
   logic                      last_term, accept, drain_cnt, p1_vld;
   logic [N_TERMS-1:0]        key_term;
   logic                      key_out;
   logic signed [2*DATA_W-1:0] p1_prod;
   logic signed [ACC_W-1:0]   acc, prod_ext;
   logic signed [OUT_W-1:0]   res_val;
   logic                      res_sat;
   logic                      unused_key;

   assign last_term  = (term_cnt == IW'(N_TERMS-1));
   assign accept     = in_vld && in_rdy;
   assign prod_ext   = ACC_W'(p1_prod);
   assign unused_key = ^locking_key;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      ap_idle        = 1'b0;
      ap_done        = 1'b0;
      ap_ready       = 1'b0;
      out_acc_ap_vld = 1'b0;
      in_rdy         = 1'b0;
      case (state)
         S_IDLE: begin
            ap_idle = !ap_start;
            if (ap_start) state_nxt = S_ACC;
         end
         S_ACC: begin
            in_rdy = 1'b1;
            if (in_vld && last_term) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
         S_DONE: begin
            ap_done        = 1'b1;
            ap_ready       = 1'b1;
            out_acc_ap_vld = 1'b1;
            state_nxt      = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Key bit N_TERMS picks saturation vs. plain truncation of the final sum.
   always_comb begin
      res_val = acc[OUT_W-1:0];
      res_sat = 1'b0;
      if (key_out) begin
         if (acc > SAT_MAX) begin
            res_val = SAT_MAX[OUT_W-1:0];
            res_sat = 1'b1;
         end else if (acc < SAT_MIN) begin
            res_val = SAT_MIN[OUT_W-1:0];
            res_sat = 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         term_cnt  <= '0;
         p1_idx    <= '0;
         p1_prod   <= '0;
         p1_vld    <= 1'b0;
         drain_cnt <= 1'b0;
         acc       <= '0;
         key_term  <= '0;
         key_out   <= 1'b0;
         out_acc   <= '0;
         out_sat   <= 1'b0;
      end else begin
         p1_vld    <= accept;
         drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
         if (accept) begin
            p1_prod  <= in_a * in_b;
            p1_idx   <= term_cnt;
            term_cnt <= last_term ? '0 : term_cnt + 1'b1;
         end
         if (state == S_IDLE && ap_start) begin
            acc      <= acc_init;
            key_term <= locking_key[N_TERMS-1:0];
            key_out  <= locking_key[N_TERMS];
            term_cnt <= '0;
         end else if (p1_vld) begin
            acc <= key_term[p1_idx] ? acc + prod_ext : acc - prod_ext;
         end
         // acc is final by the second drain cycle; capture on the edge into DONE.
         if (state == S_DRAIN && drain_cnt) begin
            out_acc <= res_val;
            out_sat <= res_sat;
         end
      end
   end

endmodule

// File: tb/tb_hls_macc_obf_param.sv
// Scoreboard bench for hls_macc_obf_param: expected results are queued at start and
// checked when ap_done fires; latency, pulse width, reset and back-to-back are checked inline.
module tb_hls_macc_obf_param;

   logic                ap_clk = 1'b0;
   logic                ap_rst, ap_start, in_vld;
   logic                ap_done, ap_idle, ap_ready, in_rdy, out_acc_ap_vld, out_sat;
   logic signed [33:0]  acc_init;
   logic signed [15:0]  in_a, in_b, out_acc;
   logic [1023:0]       locking_key;

   typedef struct {longint acc; longint sat;} exp_t;
   exp_t   sb[$];
   int     n_cmp = 0, n_err = 0;
   int     cyc = 0, done_cnt = 0, last_done = 0, prev_done = 0, acc_seen = 0;
   int     va[4], vb[4];

   hls_macc_obf_param dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
      .ap_idle(ap_idle), .ap_ready(ap_ready), .acc_init(acc_init), .in_a(in_a),
      .in_b(in_b), .in_vld(in_vld), .in_rdy(in_rdy), .out_acc(out_acc),
      .out_acc_ap_vld(out_acc_ap_vld), .out_sat(out_sat), .locking_key(locking_key)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc++;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge ap_clk) begin
      if (!ap_rst && in_vld && in_rdy) acc_seen++;
      if (ap_done) begin
         exp_t e;
         done_cnt++;
         prev_done = last_done;
         last_done = cyc;
         check("ready_with_done", ap_ready, 1);
         check("vld_with_done", out_acc_ap_vld, 1);
         check("sb_has_entry", longint'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_acc", longint'(out_acc), e.acc);
            check("out_sat", out_sat, e.sat);
         end
      end
   end

   task automatic wait_rdy();
      for (int k = 0; k < 50; k++) begin
         if (in_rdy) return;
         @(posedge ap_clk); #1;
      end
      check("wait_rdy_timeout", in_rdy, 1);
   endtask

   // Drives the four terms; pat gives in_vld for the first 7 cycles (LSB first).
   task automatic feed(input logic [6:0] pat, input bit flip);
      int idx = 0;
      int c = 0;
      while (idx < 4 && c < 200) begin
         in_vld = (c < 7) ? pat[c] : 1'b1;
         in_a   = 16'(va[idx]);
         in_b   = 16'(vb[idx]);
         @(negedge ap_clk);
         if (in_vld && in_rdy) idx++;
         @(posedge ap_clk); #1;
         c++;
         if (flip && idx == 2) locking_key = '0;
      end
      in_vld = 1'b0;
      if (idx < 4) check("feed_timeout", idx, 4);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge ap_clk);
         if (ap_done) begin
            n = k;
            return;
         end
      end
   endtask

   task automatic run_txn(input string tag, input logic [4:0] key, input longint init,
                          input logic [6:0] pat, input bit flip, input bit hold,
                          input longint e_acc, input longint e_sat);
      int n;
      locking_key      = '1;
      locking_key[4:0] = key;
      acc_init         = 34'(init);
      sb.push_back('{e_acc, e_sat});
      acc_seen = 0;
      ap_start = 1'b1;
      wait_rdy();
      if (!hold) ap_start = 1'b0;
      feed(pat, flip);
      check({tag, "_rdy_drop"}, in_rdy, 0);
      wait_done(n);
      check({tag, "_latency"}, n, 3);
      check({tag, "_accepts"}, acc_seen, 4);
      @(negedge ap_clk);
      check({tag, "_pulse"}, ap_done, 0);
      if (hold) check({tag, "_idle_low"}, ap_idle, 0);
      @(posedge ap_clk); #1;
   endtask

   task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3);
      va = '{a0, a1, a2, a3};
      vb = '{b0, b1, b2, b3};
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int dc;
      ap_rst = 1'b1; ap_start = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0;
      acc_init = '0; locking_key = '1;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      check("rst_idle", ap_idle, 1);
      check("rst_done", ap_done, 0);
      check("rst_rdy", in_rdy, 0);
      check("rst_acc", longint'(out_acc), 0);
      check("rst_sat", out_sat, 0);
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      @(posedge ap_clk); #1;

      set_ops(1, 2, 3, 4, 5, 6, 7, 8);
      run_txn("t1", 5'b11111, 10, 7'h7F, 0, 0, 80, 0);
      run_txn("t2", 5'b11101, 10, 7'h7F, 0, 0, 56, 0);
      run_txn("t2_flip", 5'b11101, 10, 7'h7F, 1, 0, 56, 0);
      set_ops(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
      run_txn("t3_sat", 5'b11111, 0, 7'h7F, 0, 0, 32767, 1);
      run_txn("t3_wrap", 5'b01111, 0, 7'h7F, 0, 0, 4, 0);
      set_ops(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767);
      run_txn("t4_negsat", 5'b11111, 0, 7'h7F, 0, 0, -32768, 1);
      set_ops(1, 2, 3, 4, 5, 6, 7, 8);
      run_txn("t5_bubble", 5'b11111, 10, 7'b1011001, 0, 0, 80, 0);

      // Reset after two accepted terms: no result may appear.
      dc = done_cnt;
      locking_key = '1; acc_init = 34'sd10;
      ap_start = 1'b1;
      wait_rdy();
      ap_start = 1'b0;
      in_vld = 1'b1; in_a = 16'sd1; in_b = 16'sd5;
      @(posedge ap_clk); #1;
      in_a = 16'sd2; in_b = 16'sd6;
      @(posedge ap_clk); #1;
      ap_rst = 1'b1; in_vld = 1'b0;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("t6_idle", ap_idle, 1);
      check("t6_acc", longint'(out_acc), 0);
      check("t6_sat", out_sat, 0);
      check("t6_rdy", in_rdy, 0);
      repeat (8) @(posedge ap_clk);
      #1;
      check("t6_no_done", done_cnt, dc);

      run_txn("t6_clean", 5'b11111, 10, 7'h7F, 0, 0, 80, 0);
      run_txn("t6_b2b_a", 5'b11111, 10, 7'h7F, 0, 1, 80, 0);
      run_txn("t6_b2b_b", 5'b11111, 10, 7'h7F, 0, 0, 80, 0);
      check("t6_b2b_gap", last_done - prev_done, 8);

      repeat (3) @(posedge ap_clk);
      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
